// File: rtl/multicycle_issue_retire.sv
// multicycle_issue_retire: issue/retire control and tag shadow pipe for a fixed-latency pipelined unit
module multicycle_issue_retire #(
    parameter int LATENCY = 4,
    parameter int SIZE    = 32,
    parameter int TAG_W   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [SIZE-1:0]            issue_instr,
    output logic [SIZE-1:0]            fu_instr,
    output logic                       fu_enable,
    input  logic [SIZE-1:0]            fu_result,
    output logic                       ret_valid,
    input  logic                       ret_ready,
    output logic [SIZE-1:0]            ret_data,
    output logic [TAG_W-1:0]           ret_tag,
    output logic [$clog2(LATENCY)-1:0] in_flight,
    output logic [15:0]                retired_cnt
);
    localparam int CNT_W = $clog2(LATENCY);
    logic [LATENCY-1:1]            vld_q, vld_d;
    logic [LATENCY-1:1][TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0]              tag_ctr_q, tag_ctr_d;
    logic [CNT_W-1:0]              in_flight_q, in_flight_d;
    logic [15:0]                   retired_q, retired_d;
    logic                          stall, fire;

    // handshake decode; stall depends only on the retire side, never on issue_valid
    always_comb begin
        ret_valid   = vld_q[LATENCY-1];
        ret_tag     = tag_q[LATENCY-1];
        ret_data    = fu_result;
        stall       = ret_valid & ~ret_ready;
        fu_enable   = ~stall;
        issue_ready = ~stall & ~flush & reset;
        fire        = issue_valid & issue_ready;
        fu_instr    = fire ? issue_instr : '0;
    end

    // shadow pipe moves in lockstep with the unit; flush drops every in-flight op
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        if (fu_enable) begin
            vld_d[1] = fire;
            tag_d[1] = tag_ctr_q;
            for (int i = 2; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
        end
        if (flush) vld_d = '0;
        in_flight_d = '0;
        for (int i = 1; i < LATENCY; i++) in_flight_d = in_flight_d + CNT_W'(vld_d[i]);
        tag_ctr_d = tag_ctr_q + TAG_W'(fire);
        retired_d = retired_q + 16'(ret_valid & ret_ready);
    end

    // state registers, cleared asynchronously so in-flight ops vanish at once on reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q       <= '0;
            tag_q       <= '0;
            tag_ctr_q   <= '0;
            in_flight_q <= '0;
            retired_q   <= '0;
        end else begin
            vld_q       <= vld_d;
            tag_q       <= tag_d;
            tag_ctr_q   <= tag_ctr_d;
            in_flight_q <= in_flight_d;
            retired_q   <= retired_d;
        end
    end

    assign in_flight   = in_flight_q;
    assign retired_cnt = retired_q;
endmodule

// File: tb/tb_multicycle_issue_retire.sv
// tb_multicycle_issue_retire: directed stimulus with a queue scoreboard for the issue/retire block
module tb_multicycle_issue_retire;
    localparam int LATENCY = 4;
    localparam int SIZE    = 32;
    localparam int TAG_W   = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic issue_valid = 1'b0;
    logic ret_ready = 1'b1;
    logic [SIZE-1:0] issue_instr = '0;
    logic issue_ready, fu_enable, ret_valid;
    logic [SIZE-1:0] fu_instr, fu_result, ret_data;
    logic [TAG_W-1:0] ret_tag;
    logic [1:0] in_flight;
    logic [15:0] retired_cnt;
    logic [SIZE-1:0] fu_pipe [1:LATENCY-1] = '{default: '0};
    logic [SIZE+TAG_W-1:0] sb [$];
    logic [TAG_W-1:0] exp_tag = '0;
    int total = 0;
    int bad = 0;

    multicycle_issue_retire #(.LATENCY(LATENCY), .SIZE(SIZE), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
        .fu_instr(fu_instr), .fu_enable(fu_enable), .fu_result(fu_result),
        .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_data(ret_data), .ret_tag(ret_tag),
        .in_flight(in_flight), .retired_cnt(retired_cnt)
    );

    // free-running clock
    always #5 clock = ~clock;

    // the pipelined unit itself: LATENCY-1 enabled register stages
    always @(posedge clock) begin
        if (fu_enable) begin
            fu_pipe[1] <= fu_instr;
            for (int i = 2; i < LATENCY; i++) fu_pipe[i] <= fu_pipe[i-1];
        end
    end
    assign fu_result = fu_pipe[LATENCY-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        issue_valid = 1'b0;
        flush = 1'b0;
        ret_ready = 1'b1;
        repeat (2) step();
        reset = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        issue_valid = 1'b0;
        while ((sb.size() != 0 || in_flight != 0) && n < 50) begin
            step();
            n++;
        end
        chk("drain_budget", 32'(n < 50), 1);
    endtask

    // monitor: pop on every retire handshake, push on every issue handshake
    initial forever begin
        logic [SIZE+TAG_W-1:0] e;
        @(negedge clock);
        if (!reset) begin
            sb.delete();
            exp_tag = '0;
        end else begin
            if (ret_valid && ret_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire: got data %0h tag %0h expected none", ret_data, ret_tag);
                end else begin
                    e = sb.pop_front();
                    chk("ret_data", ret_data, e[SIZE+TAG_W-1:TAG_W]);
                    chk("ret_tag", 32'(ret_tag), 32'(e[TAG_W-1:0]));
                end
            end
            if (flush) sb.delete();
            if (issue_valid && issue_ready) begin
                sb.push_back({issue_instr, exp_tag});
                exp_tag++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int idx, peak;
        #2;
        chk("rst_ret_valid", 32'(ret_valid), 0);
        chk("rst_fu_enable", 32'(fu_enable), 1);
        chk("rst_issue_ready", 32'(issue_ready), 0);
        chk("rst_in_flight", 32'(in_flight), 0);
        chk("rst_retired", 32'(retired_cnt), 0);

        // single op
        do_reset();
        for (int c = 0; c < 6; c++) begin
            issue_valid = (c == 0);
            issue_instr = 32'h11;
            @(negedge clock);
            chk("t1_ret_valid", 32'(ret_valid), 32'(c == 3));
            if (c < 2) chk("t1_fu_instr", fu_instr, c == 0 ? 32'h11 : 32'h0);
            step();
        end
        chk("t1_retired", 32'(retired_cnt), 1);

        // back-to-back stream
        do_reset();
        peak = 0;
        for (int c = 0; c < 12; c++) begin
            issue_valid = (c < 6);
            issue_instr = 32'hA0 + 32'(c);
            @(negedge clock);
            chk("t2_ret_valid", 32'(ret_valid), 32'(c >= 3 && c <= 8));
            if (int'(in_flight) > peak) peak = int'(in_flight);
            step();
        end
        chk("t2_peak", 32'(peak), 3);
        chk("t2_retired", 32'(retired_cnt), 6);

        // backpressure during a stream
        do_reset();
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            issue_valid = (idx < 8);
            issue_instr = 32'hB0 + 32'(idx);
            ret_ready = !(c >= 3 && c <= 6);
            @(negedge clock);
            if (c >= 3 && c <= 6) begin
                chk("t3_ret_valid", 32'(ret_valid), 1);
                chk("t3_ret_data", ret_data, 32'hB0);
                chk("t3_ret_tag", 32'(ret_tag), 0);
                chk("t3_fu_enable", 32'(fu_enable), 0);
                chk("t3_issue_ready", 32'(issue_ready), 0);
                chk("t3_fu_instr", fu_instr, 0);
                chk("t3_in_flight", 32'(in_flight), 3);
            end
            if (issue_valid && issue_ready) idx++;
            step();
        end
        drain();
        chk("t3_retired", 32'(retired_cnt), 8);

        // flush with ops in flight
        do_reset();
        for (int c = 0; c < 10; c++) begin
            issue_valid = (c <= 4);
            issue_instr = c < 3 ? 32'hC0 + 32'(c) : 32'hDD;
            flush = (c == 3);
            @(negedge clock);
            if (c == 3) begin
                chk("t4_issue_ready", 32'(issue_ready), 0);
                chk("t4_ret_valid_flush", 32'(ret_valid), 1);
            end
            if (c == 4) chk("t4_in_flight", 32'(in_flight), 0);
            if (c >= 4 && c <= 6) chk("t4_no_ret", 32'(ret_valid), 0);
            if (c == 7) begin
                chk("t4_ret_valid", 32'(ret_valid), 1);
                chk("t4_tag", 32'(ret_tag), 3);
                chk("t4_data", ret_data, 32'hDD);
            end
            step();
        end
        flush = 1'b0;
        chk("t4_retired", 32'(retired_cnt), 2);

        // tag wrap over 18 ops
        do_reset();
        for (int c = 0; c < 24; c++) begin
            issue_valid = (c < 18);
            issue_instr = 32'h500 + 32'(c);
            @(negedge clock);
            if (c == 18) chk("t5_tag15", 32'(ret_tag), 15);
            if (c == 19) begin
                chk("t5_tag_wrap", 32'(ret_tag), 0);
                chk("t5_data16", ret_data, 32'h510);
            end
            step();
        end
        drain();
        chk("t5_retired", 32'(retired_cnt), 18);

        // asynchronous reset with ops in flight
        for (int c = 0; c < 3; c++) begin
            issue_valid = (c < 2);
            issue_instr = 32'h61 + 32'(c);
            @(negedge clock);
            step();
        end
        chk("t6_pre_ret_valid", 32'(ret_valid), 1);
        reset = 1'b0;
        #1;
        chk("t6_ret_valid", 32'(ret_valid), 0);
        chk("t6_in_flight", 32'(in_flight), 0);
        chk("t6_issue_ready", 32'(issue_ready), 0);
        chk("t6_fu_enable", 32'(fu_enable), 1);
        chk("t6_retired", 32'(retired_cnt), 0);
        step();
        step();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            issue_valid = (c == 0);
            issue_instr = 32'h66;
            @(negedge clock);
            chk("t6_post_ret_valid", 32'(ret_valid), 32'(c == 3));
            if (c == 3) chk("t6_post_tag", 32'(ret_tag), 0);
            step();
        end
        chk("t6_post_retired", 32'(retired_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
